// File: rtl/apb_nslave_master_if.sv
// Command port and APB fabric bundle for apb_nslave_master.
// master: bridge side; slave: command source and slave fabric side.
interface apb_nslave_master_if #(
    parameter int AW         = 9,
    parameter int DW         = 8,
    parameter int NUM_SLAVES = 4
);
    logic                     transfer;
    logic                     read_write;
    logic [AW-1:0]            apb_write_paddr;
    logic [DW-1:0]            apb_write_data;
    logic [AW-1:0]            apb_read_paddr;
    logic                     cmd_ready;
    logic [DW-1:0]            apb_read_data_out;
    logic                     rd_valid;
    logic                     wr_done;
    logic                     xfer_err;
    logic [NUM_SLAVES-1:0]    psel;
    logic                     penable;
    logic                     pwrite;
    logic [AW-1:0]            paddr;
    logic [DW-1:0]            pwdata;
    logic [NUM_SLAVES*DW-1:0] prdata;
    logic [NUM_SLAVES-1:0]    pready;
    logic [NUM_SLAVES-1:0]    pslverr;

    modport master (
        input  transfer, read_write, apb_write_paddr, apb_write_data,
        input  apb_read_paddr, prdata, pready, pslverr,
        output cmd_ready, apb_read_data_out, rd_valid, wr_done,
        output xfer_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output transfer, read_write, apb_write_paddr, apb_write_data,
        output apb_read_paddr, prdata, pready, pslverr,
        input  cmd_ready, apb_read_data_out, rd_valid, wr_done,
        input  xfer_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_nslave_master.sv
// APB master bridge: command port in, NUM_SLAVES APB slaves out.
// Ports: pclk, preset (async, active-high), bus (apb_nslave_master_if.master).
// Top SEL_W address bits pick the slave; out-of-range index -> decode error.
// Optional macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES waits.
module apb_nslave_master #(
    parameter int AW             = 9,
    parameter int DW             = 8,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 pclk,
    input logic                 preset,
    apb_nslave_master_if.master bus
);
    localparam int SEL_W = (NUM_SLAVES > 2) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [SEL_W:0] NS = (SEL_W+1)'(NUM_SLAVES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [AW-1:0]         paddr_q, paddr_d;
    logic [DW-1:0]         pwdata_q, pwdata_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_done_q, wr_done_d;
    logic                  xfer_err_q, xfer_err_d;

    logic [AW-1:0]         cmd_addr;
    logic [SEL_W-1:0]      cmd_idx;
    logic                  cmd_ok;
    logic                  cmd_ready;
    logic                  acc;
    logic                  load;
    logic                  sel_rdy;
    logic                  sel_err;
    logic [DW-1:0]         sel_rdata;
    logic                  timeout;

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Only the addressed slave's response is observed.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_rdy   = bus.pready[i];
                sel_err   = bus.pslverr[i];
                sel_rdata = bus.prdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        cmd_addr = bus.read_write ? bus.apb_read_paddr
                                  : bus.apb_write_paddr;
        cmd_idx  = cmd_addr[AW-1 -: SEL_W];
        cmd_ok   = {1'b0, cmd_idx} < NS;
        // Ready in the completing ACCESS cycle allows back-to-back.
        cmd_ready = (state_q == IDLE) ||
                    ((state_q == ACCESS) && sel_rdy);
        acc  = bus.transfer && cmd_ready;
        load = acc && cmd_ok;
    end

`ifdef APB_TIMEOUT_EN
    always_comb begin
        timeout = (state_q == ACCESS) && !sel_rdy &&
                  (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        cnt_d = cnt_q;
        if (state_q == SETUP)
            cnt_d = '0;
        else if ((state_q == ACCESS) && !sel_rdy)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            idx_q      <= '0;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            xfer_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            idx_q      <= idx_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            xfer_err_q <= xfer_err_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (acc) state_d = cmd_ok ? SETUP : ERR;
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (sel_rdy) begin
                    if (acc) state_d = cmd_ok ? SETUP : ERR;
                    else     state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            ERR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values.
    always_comb begin
        rw_d       = rw_q;
        idx_d      = idx_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;
        xfer_err_d = 1'b0;

        if (acc) begin
            rw_d  = bus.read_write;
            idx_d = cmd_idx;
        end

        unique case (state_q)
            IDLE: ;
            SETUP: penable_d = 1'b1;
            ACCESS: begin
                if (sel_rdy) begin
                    rd_valid_d = rw_q;
                    wr_done_d  = !rw_q;
                    xfer_err_d = sel_err;
                    if (rw_q) rdata_d = sel_rdata;
                    psel_d     = '0;
                    penable_d  = 1'b0;
                end else if (timeout) begin
                    rd_valid_d = rw_q;
                    wr_done_d  = !rw_q;
                    xfer_err_d = 1'b1;
                    psel_d     = '0;
                    penable_d  = 1'b0;
                end
            end
            ERR: begin
                rd_valid_d = rw_q;
                wr_done_d  = !rw_q;
                xfer_err_d = 1'b1;
            end
            default: ;
        endcase

        // New SETUP overrides the completion drop of psel.
        if (load) begin
            for (int i = 0; i < NUM_SLAVES; i++)
                psel_d[i] = (cmd_idx == SEL_W'(i));
            penable_d = 1'b0;
            pwrite_d  = !bus.read_write;
            paddr_d   = cmd_addr;
            pwdata_d  = bus.apb_write_data;
        end
    end

    assign bus.cmd_ready         = cmd_ready;
    assign bus.apb_read_data_out = rdata_q;
    assign bus.rd_valid          = rd_valid_q;
    assign bus.wr_done           = wr_done_q;
    assign bus.xfer_err          = xfer_err_q;
    assign bus.psel              = psel_q;
    assign bus.penable           = penable_q;
    assign bus.pwrite            = pwrite_q;
    assign bus.paddr             = paddr_q;
    assign bus.pwdata            = pwdata_q;
endmodule

// File: tb/tb_apb_nslave_master.sv
// Directed testbench for apb_nslave_master.
// Main instance has 4 slaves; a second with 3 slaves exercises decode error.
module tb_apb_nslave_master;
    logic pclk;
    logic preset;
    int   checks;
    int   failures;

    apb_nslave_master_if #(.AW(9), .DW(8), .NUM_SLAVES(4)) b4 ();
    apb_nslave_master_if #(.AW(9), .DW(8), .NUM_SLAVES(3)) b3 ();

    apb_nslave_master #(
        .AW(9), .DW(8), .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (b4.master)
    );

    apb_nslave_master #(
        .AW(9), .DW(8), .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)
    ) u_dut3 (
        .pclk   (pclk),
        .preset (preset),
        .bus    (b3.master)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        b4.transfer = 0; b4.read_write = 0;
        b4.apb_write_paddr = '0; b4.apb_write_data = '0;
        b4.apb_read_paddr = '0; b4.prdata = '0;
        b4.pready = '1; b4.pslverr = '0;
        b3.transfer = 0; b3.read_write = 0;
        b3.apb_write_paddr = '0; b3.apb_write_data = '0;
        b3.apb_read_paddr = '0; b3.prdata = '0;
        b3.pready = '1; b3.pslverr = '0;
        #12;
        checks++;
        if (b4.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_cmd_ready got=%b exp=1", b4.cmd_ready);
        end
        checks++;
        if ({b4.psel, b4.penable, b4.pwrite, b4.rd_valid,
             b4.wr_done, b4.xfer_err} !== 9'b0) begin
            failures++;
            $display("FAIL rst_ctrl got psel=%b pen=%b", b4.psel, b4.penable);
        end
        checks++;
        if ({b4.paddr, b4.pwdata, b4.apb_read_data_out} !== 25'b0) begin
            failures++;
            $display("FAIL rst_data got paddr=%h pwdata=%h rd=%h",
                     b4.paddr, b4.pwdata, b4.apb_read_data_out);
        end
        preset = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        b4.pready = 4'b1111;
        b4.transfer = 1; b4.read_write = 0;
        b4.apb_write_paddr = 9'h1A5; b4.apb_write_data = 8'h3C;
        tick();
        b4.transfer = 0;
        checks++;
        if ({b4.psel, b4.penable, b4.pwrite, b4.cmd_ready} !== 7'b1000_0_1_0)
        begin
            failures++;
            $display("FAIL wr_setup_ctrl got psel=%b pen=%b pw=%b rdy=%b",
                     b4.psel, b4.penable, b4.pwrite, b4.cmd_ready);
        end
        checks++;
        if (b4.paddr !== 9'h1A5 || b4.pwdata !== 8'h3C) begin
            failures++;
            $display("FAIL wr_setup_data got paddr=%h pwdata=%h exp=1a5 3c",
                     b4.paddr, b4.pwdata);
        end
        tick();
        checks++;
        if (b4.penable !== 1'b1 || b4.psel !== 4'b1000 ||
            b4.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_access got pen=%b psel=%b rdy=%b exp=1 1000 1",
                     b4.penable, b4.psel, b4.cmd_ready);
        end
        tick();
        checks++;
        if ({b4.wr_done, b4.xfer_err, b4.rd_valid} !== 3'b100) begin
            failures++;
            $display("FAIL wr_done got wd=%b err=%b rv=%b exp=1 0 0",
                     b4.wr_done, b4.xfer_err, b4.rd_valid);
        end
        checks++;
        if (b4.psel !== 4'b0 || b4.penable !== 1'b0) begin
            failures++;
            $display("FAIL wr_release got psel=%b pen=%b exp=0 0",
                     b4.psel, b4.penable);
        end
        tick();
        checks++;
        if (b4.wr_done !== 1'b0) begin
            failures++;
            $display("FAIL wr_pulse_width got=%b exp=0", b4.wr_done);
        end
    endtask

    task automatic test_read_wait();
        b4.pready = 4'b1110;
        b4.prdata = 32'h4433_22A7;
        b4.transfer = 1; b4.read_write = 1;
        b4.apb_read_paddr = 9'h045;
        tick();
        b4.transfer = 0;
        checks++;
        if (b4.psel !== 4'b0001 || b4.pwrite !== 1'b0 ||
            b4.paddr !== 9'h045) begin
            failures++;
            $display("FAIL rd_setup got psel=%b pw=%b paddr=%h exp=0001 0 045",
                     b4.psel, b4.pwrite, b4.paddr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (b4.penable !== 1'b1 || b4.rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL rd_wait%0d got pen=%b rv=%b exp=1 0",
                         i, b4.penable, b4.rd_valid);
            end
            if (i == 3) b4.pready = 4'b1111;
        end
        tick();
        checks++;
        if (b4.rd_valid !== 1'b1 || b4.xfer_err !== 1'b0 ||
            b4.apb_read_data_out !== 8'hA7) begin
            failures++;
            $display("FAIL rd_done got rv=%b err=%b data=%h exp=1 0 a7",
                     b4.rd_valid, b4.xfer_err, b4.apb_read_data_out);
        end
    endtask

    task automatic test_back_to_back();
        b4.pready = 4'b1111;
        b4.prdata = 32'h005A_0000;
        b4.transfer = 1; b4.read_write = 0;
        b4.apb_write_paddr = 9'h080; b4.apb_write_data = 8'h55;
        b4.apb_read_paddr = 9'h100;
        tick();
        b4.read_write = 1;
        checks++;
        if (b4.psel !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_first got psel=%b exp=0010", b4.psel);
        end
        tick();
        checks++;
        if (b4.psel !== 4'b0010 || b4.penable !== 1'b1 ||
            b4.paddr !== 9'h080) begin
            failures++;
            $display("FAIL b2b_access1 got psel=%b pen=%b paddr=%h",
                     b4.psel, b4.penable, b4.paddr);
        end
        tick();
        b4.transfer = 0;
        checks++;
        if (b4.wr_done !== 1'b1 || b4.psel !== 4'b0100 ||
            b4.penable !== 1'b0 || b4.paddr !== 9'h100 ||
            b4.pwrite !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got wd=%b psel=%b pen=%b paddr=%h",
                     b4.wr_done, b4.psel, b4.penable, b4.paddr);
        end
        tick();
        checks++;
        if (b4.penable !== 1'b1 || b4.psel !== 4'b0100) begin
            failures++;
            $display("FAIL b2b_access2 got pen=%b psel=%b",
                     b4.penable, b4.psel);
        end
        tick();
        checks++;
        if (b4.rd_valid !== 1'b1 || b4.apb_read_data_out !== 8'h5A) begin
            failures++;
            $display("FAIL b2b_rdata got rv=%b data=%h exp=1 5a",
                     b4.rd_valid, b4.apb_read_data_out);
        end
    endtask

    task automatic test_slave_error();
        b4.pready = 4'b1111;
        b4.pslverr = 4'b0010;
        b4.transfer = 1; b4.read_write = 0;
        b4.apb_write_paddr = 9'h0FF; b4.apb_write_data = 8'h11;
        tick();
        b4.transfer = 0;
        tick();
        tick();
        checks++;
        if (b4.wr_done !== 1'b1 || b4.xfer_err !== 1'b1) begin
            failures++;
            $display("FAIL slverr got wd=%b err=%b exp=1 1",
                     b4.wr_done, b4.xfer_err);
        end
        // Errors from unselected slaves must not leak in.
        b4.pslverr = 4'b1101;
        b4.transfer = 1;
        tick();
        b4.transfer = 0;
        tick();
        tick();
        checks++;
        if (b4.wr_done !== 1'b1 || b4.xfer_err !== 1'b0) begin
            failures++;
            $display("FAIL slverr_unsel got wd=%b err=%b exp=1 0",
                     b4.wr_done, b4.xfer_err);
        end
        b4.pslverr = '0;
        tick();
    endtask

    task automatic test_decode_error();
        b3.pready = 3'b111;
        b3.prdata = 24'h00_6B_00;
        b3.transfer = 1; b3.read_write = 1;
        b3.apb_read_paddr = 9'h080;
        tick();
        b3.transfer = 0;
        tick();
        tick();
        checks++;
        if (b3.rd_valid !== 1'b1 || b3.apb_read_data_out !== 8'h6B) begin
            failures++;
            $display("FAIL dec_pre got rv=%b data=%h exp=1 6b",
                     b3.rd_valid, b3.apb_read_data_out);
        end
        b3.prdata = 24'hEE_EE_EE;
        b3.transfer = 1;
        b3.apb_read_paddr = 9'h180;
        tick();
        b3.transfer = 0;
        checks++;
        if (b3.psel !== 3'b000 || b3.cmd_ready !== 1'b0 ||
            b3.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL dec_err_state got psel=%b rdy=%b rv=%b exp=0 0 0",
                     b3.psel, b3.cmd_ready, b3.rd_valid);
        end
        tick();
        checks++;
        if (b3.rd_valid !== 1'b1 || b3.xfer_err !== 1'b1 ||
            b3.psel !== 3'b000 || b3.apb_read_data_out !== 8'h6B) begin
            failures++;
            $display("FAIL dec_err got rv=%b err=%b psel=%b data=%h",
                     b3.rd_valid, b3.xfer_err, b3.psel,
                     b3.apb_read_data_out);
        end
        tick();
        checks++;
        if (b3.rd_valid !== 1'b0 || b3.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL dec_idle got rv=%b rdy=%b exp=0 1",
                     b3.rd_valid, b3.cmd_ready);
        end
    endtask

    task automatic test_reset_mid_access();
        b4.pready = 4'b1110;
        b4.transfer = 1; b4.read_write = 1;
        b4.apb_read_paddr = 9'h045;
        tick();
        b4.transfer = 0;
        tick();
        checks++;
        if (b4.penable !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got pen=%b exp=1", b4.penable);
        end
        #2 preset = 1'b1;
        #1;
        checks++;
        if (b4.psel !== 4'b0 || b4.penable !== 1'b0 ||
            b4.cmd_ready !== 1'b1 || b4.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid got psel=%b pen=%b rdy=%b rv=%b",
                     b4.psel, b4.penable, b4.cmd_ready, b4.rd_valid);
        end
        b4.pready = 4'b1111;
        tick();
        #2 preset = 1'b0;
        tick();
        checks++;
        if (b4.rd_valid !== 1'b0 || b4.psel !== 4'b0) begin
            failures++;
            $display("FAIL rstmid_after got rv=%b psel=%b exp=0 0",
                     b4.rd_valid, b4.psel);
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        b4.prdata = 32'h0000_00C3;
        b4.pready = 4'b1110;
        b4.transfer = 1; b4.read_write = 1;
        b4.apb_read_paddr = 9'h045;
        tick();
        b4.transfer = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (b4.rd_valid !== 1'b1 && n < 40);
        checks++;
        if (n != 17) begin
            failures++;
            $display("FAIL timeout_len got=%0d exp=17", n);
        end
        checks++;
        if (b4.xfer_err !== 1'b1 || b4.psel !== 4'b0 ||
            b4.penable !== 1'b0 || b4.apb_read_data_out !== 8'h00) begin
            failures++;
            $display("FAIL timeout got err=%b psel=%b pen=%b data=%h",
                     b4.xfer_err, b4.psel, b4.penable,
                     b4.apb_read_data_out);
        end
        b4.pready = 4'b1111;
        tick();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_back_to_back();
        test_slave_error();
        test_decode_error();
        test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
